// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command frame decoder and the game logic that consumes it.
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    HUNT   = 3'd0,
    CMD    = 3'd1,
    ARG_HI = 3'd2,
    ARG_LO = 3'd3,
    CHK    = 3'd4
  } state_e;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_LEN         = 5;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_MOVE  = 8'h10;
  localparam logic [7:0] OP_FIRE  = 8'h20;
  localparam logic [7:0] OP_RESET = 8'hFF;

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Byte-stream input and command-output handshakes of the decoder; slave is the decoder side.
interface spi_cmd_decoder_if;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_clear;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic        cmd_valid;
  logic        cmd_ready;

  modport slave (
    input  byte_data, byte_valid, cmd_ready,
    output byte_clear, cmd_op, cmd_arg, cmd_valid
  );

  modport master (
    output byte_data, byte_valid, cmd_ready,
    input  byte_clear, cmd_op, cmd_arg, cmd_valid
  );
endinterface

// File: rtl/byte_timeout_timer.sv
// Inter-byte watchdog: counts enabled cycles and pulses expire when the count reaches TIMEOUT_CYCLES-1.
module byte_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int unsigned   W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0]  LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_comb expire = enable & (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear || expire) count <= '0;
    else if (enable)              count <= count + W'(1);
  end
endmodule

// File: rtl/spi_cmd_decoder.sv
// Assembles SYNC/CMD/ARG_HI/ARG_LO/CHK frames from the SPI byte stream and presents good
// commands in a one-entry valid/ready output register, with checksum, timeout and overrun errors.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned ERR_W          = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_cmd_decoder_if.slave     bus,
  output logic                 err_chk,
  output logic                 err_timeout,
  output logic                 err_overrun,
  output logic [ERR_W-1:0]     err_count
);
  state_e     state;
  logic [7:0] op_q, arg_hi_q, arg_lo_q, chk_acc;
  logic       take, in_hunt, timer_clear, expire;
  logic       frame_done, chk_ok, load, chk_fail, overrun, any_err;

  // byte_clear masks take for one cycle so a still-high byte_valid is not consumed twice
  always_comb begin
    take        = bus.byte_valid & ~bus.byte_clear;
    in_hunt     = (state == HUNT);
    timer_clear = take | in_hunt;
    frame_done  = take & (state == CHK);
    chk_ok      = (bus.byte_data == chk_acc);
    load        = frame_done & chk_ok & (~bus.cmd_valid | bus.cmd_ready);
    overrun     = frame_done & chk_ok & bus.cmd_valid & ~bus.cmd_ready;
    chk_fail    = frame_done & ~chk_ok;
    any_err     = chk_fail | overrun | expire;
  end

  byte_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (~timer_clear),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= HUNT;
      op_q           <= '0;
      arg_hi_q       <= '0;
      arg_lo_q       <= '0;
      chk_acc        <= '0;
      bus.byte_clear <= 1'b0;
      bus.cmd_op     <= '0;
      bus.cmd_arg    <= '0;
      bus.cmd_valid  <= 1'b0;
      err_chk        <= 1'b0;
      err_timeout    <= 1'b0;
      err_overrun    <= 1'b0;
      err_count      <= '0;
    end else begin
      bus.byte_clear <= take;
      err_chk        <= chk_fail;
      err_timeout    <= expire;
      err_overrun    <= overrun;

      if (take) begin
        unique case (state)
          HUNT:   if (bus.byte_data == SYNC_BYTE) state <= CMD;
          CMD:    begin op_q     <= bus.byte_data; chk_acc <= bus.byte_data;           state <= ARG_HI; end
          ARG_HI: begin arg_hi_q <= bus.byte_data; chk_acc <= chk_acc ^ bus.byte_data; state <= ARG_LO; end
          ARG_LO: begin arg_lo_q <= bus.byte_data; chk_acc <= chk_acc ^ bus.byte_data; state <= CHK;    end
          CHK:    state <= HUNT;
          default: state <= HUNT;
        endcase
      end else if (expire) begin
        state <= HUNT;
      end

      // a load in the same cycle as a consumer accept keeps cmd_valid high with the new command
      if (load) begin
        bus.cmd_op    <= op_q;
        bus.cmd_arg   <= {arg_hi_q, arg_lo_q};
        bus.cmd_valid <= 1'b1;
      end else if (bus.cmd_valid && bus.cmd_ready) begin
        bus.cmd_valid <= 1'b0;
      end

      if (any_err && (err_count != '1)) err_count <= err_count + ERR_W'(1);
    end
  end
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed frames drive the decoder; expected commands and error pulses go to queues that
// independent negedge monitors pop whenever the DUT transfers a command or raises an error.
module tb_spi_cmd_decoder;
  localparam int unsigned TO    = 16;
  localparam int unsigned ERR_W = 8;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] arg;
  } cmd_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             err_chk, err_timeout, err_overrun;
  logic [ERR_W-1:0] err_count;

  spi_cmd_decoder_if bus ();

  spi_cmd_decoder #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TO),
    .ERR_W          (ERR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .err_chk     (err_chk),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  cmd_t exp_q[$];
  int   err_q[$];   // 1 = checksum, 2 = timeout, 4 = overrun

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // command scoreboard and hold-stability monitor
  logic held_prev = 1'b0;
  cmd_t held_val;
  always @(negedge clk) begin
    if (reset) begin
      held_prev = 1'b0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmd_unexpected: got op %0h arg %0h, no command expected", bus.cmd_op, bus.cmd_arg);
        end else begin
          cmd_t e;
          e = exp_q.pop_front();
          check("cmd_op", bus.cmd_op, e.op);
          check("cmd_arg", bus.cmd_arg, e.arg);
        end
      end
      if (held_prev && bus.cmd_valid && !bus.cmd_ready)
        check("cmd_hold", {bus.cmd_op, bus.cmd_arg}, held_val);
      held_prev = bus.cmd_valid & ~bus.cmd_ready;
      held_val  = {bus.cmd_op, bus.cmd_arg};
    end
  end

  // error-pulse scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      logic [2:0] code;
      code = {err_overrun, err_timeout, err_chk};
      if (code != 3'b000) begin
        if (err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL err_unexpected: got code %0h, no error expected", code);
        end else begin
          check("err_kind", code, err_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // present one byte, wait until it can be taken, then drop valid on byte_clear
  task automatic send(input logic [7:0] b, input bit ready_on_take = 1'b0);
    int n = 0;
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    while (bus.byte_clear && n < 8) begin tick(1); n++; end
    if (bus.byte_clear) begin
      checks++; errors++;
      $display("FAIL send_wait: byte_clear stuck 1, required 0");
    end
    if (ready_on_take) bus.cmd_ready = 1'b1;
    tick(1);
    check("byte_clear", bus.byte_clear, 1);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send5(input logic [7:0] b0, b1, b2, b3, b4, input bit ready_on_last = 1'b0);
    send(b0); send(b1); send(b2); send(b3); send(b4, ready_on_last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    bus.byte_data  = '0;
    bus.byte_valid = 1'b0;
    bus.cmd_ready  = 1'b1;
    tick(3);
    check("rst_cmd_valid", bus.cmd_valid, 0);
    check("rst_cmd_op", bus.cmd_op, 0);
    check("rst_cmd_arg", bus.cmd_arg, 0);
    check("rst_byte_clear", bus.byte_clear, 0);
    check("rst_errs", {err_chk, err_timeout, err_overrun}, 0);
    check("rst_err_count", err_count, 0);
    reset = 1'b0;
    tick(1);

    // 1: basic good frame
    exp_q.push_back('{op: 8'h10, arg: 16'h1234});
    send5(8'hA5, 8'h10, 8'h12, 8'h34, 8'h36);
    check("t1_valid_next", bus.cmd_valid, 1);
    tick(1);
    check("t1_valid_drop", bus.cmd_valid, 0);

    // 2: junk before SYNC silently discarded
    send(8'h00); send(8'hFF);
    exp_q.push_back('{op: 8'h01, arg: 16'h0002});
    send5(8'hA5, 8'h01, 8'h00, 8'h02, 8'h03);
    tick(1);
    check("t2_err_count", err_count, 0);

    // 3: bad checksum
    err_q.push_back(1);
    send5(8'hA5, 8'h10, 8'h12, 8'h34, 8'h00);
    check("t3_err_count", err_count, 1);
    check("t3_no_cmd", bus.cmd_valid, 0);
    tick(2);

    // 4: mid-frame timeout, then recovery
    send(8'hA5); send(8'h10);
    err_q.push_back(2);
    for (int i = 1; i < int'(TO); i++) begin
      tick(1);
      check("t4_no_timeout_yet", err_timeout, 0);
    end
    tick(1);
    check("t4_timeout", err_timeout, 1);
    check("t4_err_count", err_count, 2);
    exp_q.push_back('{op: 8'h20, arg: 16'h0001});
    send5(8'hA5, 8'h20, 8'h00, 8'h01, 8'h21);
    tick(2);

    // 4b: take landing in the expiry cycle wins
    send(8'hA5);
    tick(int'(TO) - 1);
    exp_q.push_back('{op: 8'h10, arg: 16'h0001});
    send(8'h10); send(8'h00); send(8'h01); send(8'h11);
    tick(1);
    check("t4b_err_count", err_count, 2);

    // 5: stalled consumer, overrun, then load on same-cycle accept
    bus.cmd_ready = 1'b0;
    exp_q.push_back('{op: 8'h01, arg: 16'hABCD});
    send5(8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h67);
    err_q.push_back(4);
    send5(8'hA5, 8'h02, 8'h11, 8'h22, 8'h31);
    check("t5_held_op", bus.cmd_op, 8'h01);
    check("t5_err_count", err_count, 3);
    exp_q.push_back('{op: 8'h03, arg: 16'h0005});
    send5(8'hA5, 8'h03, 8'h00, 8'h05, 8'h06, 1'b1);
    check("t5_valid_kept", bus.cmd_valid, 1);
    check("t5_new_op", bus.cmd_op, 8'h03);
    check("t5_err_count2", err_count, 3);
    tick(1);
    check("t5_valid_drop", bus.cmd_valid, 0);

    // 6a: byte_valid held through the byte_clear cycle is taken once
    tick(2);
    bus.byte_data  = 8'hA5;
    bus.byte_valid = 1'b1;
    tick(1);
    check("t6_clear_pulse", bus.byte_clear, 1);
    tick(1);
    check("t6_clear_once", bus.byte_clear, 0);
    bus.byte_valid = 1'b0;
    exp_q.push_back('{op: 8'h10, arg: 16'h1234});
    send(8'h10); send(8'h12); send(8'h34); send(8'h36);
    tick(2);

    // 6b: reset with a pending command and a frame stopped in ARG_LO
    bus.cmd_ready = 1'b0;
    send5(8'hA5, 8'h07, 8'h00, 8'h00, 8'h07);
    send(8'hA5); send(8'h10); send(8'h12);
    tick(1);
    bus.byte_data  = 8'h34;
    bus.byte_valid = 1'b1;
    reset          = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t6_rst_valid", bus.cmd_valid, 0);
    check("t6_rst_op", bus.cmd_op, 0);
    check("t6_rst_arg", bus.cmd_arg, 0);
    check("t6_rst_clear", bus.byte_clear, 0);
    check("t6_rst_err_count", err_count, 0);
    tick(1);
    check("t6_retake", bus.byte_clear, 1);
    bus.byte_valid = 1'b0;
    bus.cmd_ready  = 1'b1;
    exp_q.push_back('{op: 8'h10, arg: 16'h1234});
    send5(8'hA5, 8'h10, 8'h12, 8'h34, 8'h36);
    tick(3);
    check("end_err_count", err_count, 0);
    check("end_cmd_q_empty", exp_q.size(), 0);
    check("end_err_q_empty", err_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
